// File: rtl/sim_serial_pkg.sv
// Shared register offsets and STATUS/CONTROL bit positions for the
// buffered sim serial device.
package sim_serial_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_RXDATA  = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_CONTROL = 2'd3;

    localparam int ST_RX_AVAIL     = 0;
    localparam int ST_TX_FULL      = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_RX_OVERRUN   = 3;
    localparam int ST_TX_DROP      = 4;
    localparam int ST_RX_COUNT_LSB = 16;
    localparam int ST_TX_COUNT_LSB = 24;

    localparam int CTRL_IRQ_RX       = 0;
    localparam int CTRL_IRQ_TX_EMPTY = 1;

endpackage

// File: rtl/sim_serial_sfifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sim_serial_sfifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNTW  = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNTW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sim_serial_buffered.sv
// Memory-mapped buffered serial port: TX/RX FIFOs, STATUS and CONTROL.
// Define SERIAL_IRQ_EN to add the irq output and CONTROL register.
module sim_serial_buffered
    import sim_serial_pkg::*;
#(
    parameter int BASE  = 32,
    parameter int DEPTH = 16,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          rw,
    input  logic [31:0]   addr,
    input  logic [31:0]   d_in,
    output logic [31:0]   d_out,
    output logic [CW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [CW-1:0] rx_data,
    input  logic          rx_valid
`ifdef SERIAL_IRQ_EN
    ,
    output logic          irq
`endif
);

    localparam int CNTW = $clog2(DEPTH) + 1;

    logic [31:0]   off_full;
    logic [1:0]    off;
    logic          hit;
    logic          rd;
    logic          tx_push;
    logic          rx_rd;
    logic          st_rd;

    logic [CNTW-1:0] tx_count;
    logic [CNTW-1:0] rx_count;
    logic            tx_full;
    logic            tx_empty;
    logic            rx_full;
    logic            rx_empty;
    logic [CW-1:0]   rx_head;

    logic          rx_overrun;
    logic          tx_drop;
    logic [1:0]    ctrl;
    logic [31:0]   status;
    logic [31:0]   rd_data;
    logic          unused;

    assign unused   = ^d_in[31:CW];
    assign off_full = addr - 32'(BASE);
    assign off      = off_full[1:0];
    assign hit      = enable && (off_full < 32'd4);
    assign rd       = hit && !rw;
    assign tx_push  = hit && rw && (off == OFF_TXDATA);
    assign rx_rd    = rd && (off == OFF_RXDATA);
    assign st_rd    = rd && (off == OFF_STATUS);
    assign tx_valid = !tx_empty;

    sim_serial_sfifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .wdata (d_in[CW-1:0]),
        .pop   (tx_ready),
        .rdata (tx_data),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sim_serial_sfifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .wdata (rx_data),
        .pop   (rx_rd),
        .rdata (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        status                           = '0;
        status[ST_RX_AVAIL]              = !rx_empty;
        status[ST_TX_FULL]               = tx_full;
        status[ST_TX_EMPTY]              = tx_empty;
        status[ST_RX_OVERRUN]            = rx_overrun;
        status[ST_TX_DROP]               = tx_drop;
        status[ST_RX_COUNT_LSB +: 8]     = 8'(rx_count);
        status[ST_TX_COUNT_LSB +: 8]     = 8'(tx_count);
    end

    always_comb begin
        rd_data = '0;
        unique case (off)
            OFF_RXDATA:  rd_data = rx_empty ? '0 : 32'(rx_head);
            OFF_STATUS:  rd_data = status;
            OFF_CONTROL: rd_data = 32'(ctrl);
            default:     rd_data = '0;
        endcase
    end

    // A drop or overrun in the same cycle as a STATUS read stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_out      <= '0;
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            if (rd)
                d_out <= rd_data;
            rx_overrun <= (rx_valid && rx_full && !rx_rd)
                        || (rx_overrun && !st_rd);
            tx_drop    <= (tx_push && tx_full && !tx_ready)
                        || (tx_drop && !st_rd);
        end
    end

`ifdef SERIAL_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= '0;
            irq  <= 1'b0;
        end else begin
            if (hit && rw && (off == OFF_CONTROL))
                ctrl <= d_in[1:0];
            irq <= (ctrl[CTRL_IRQ_RX] && !rx_empty)
                || (ctrl[CTRL_IRQ_TX_EMPTY] && tx_empty);
        end
    end
`else
    assign ctrl = '0;
`endif

endmodule
